// File: rtl/can_pkg.sv
// Shared definitions for the CAN receive bit-destuffing path.
package can_pkg;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_STUFFED = 2'd2,
        ST_PASS    = 2'd3
    } can_state_e;

    localparam logic CAN_DOMINANT  = 1'b0;
    localparam logic CAN_RECESSIVE = 1'b1;

    localparam int unsigned CAN_STUFF_LEN = 5;
    localparam int unsigned CAN_IDLE_LEN  = 11;

endpackage

// File: rtl/can_run_counter.sv
// Saturating run-length counter with synchronous load; used for the stuff run and the recessive idle run.
module can_run_counter #(
    parameter int unsigned MAX = 5,
    parameter int unsigned W   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count
);

    // Run register: load wins over increment, increment stops at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {W{1'b0}};
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count < W'(MAX))) begin
            count <= count + W'(1);
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/can_bit_destuff.sv
// CAN receive destuffer: SOF detection, stuff-bit removal, CRC window and bus-idle tracking.
module can_bit_destuff
    import can_pkg::*;
#(
    parameter int unsigned STUFF_LEN = CAN_STUFF_LEN,
    parameter int unsigned IDLE_LEN  = CAN_IDLE_LEN,
    parameter int unsigned CNT_W     = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic rx_bit,
    input  logic stuff_en,
    output logic dout,
    output logic dout_valid,
    output logic crc_win,
    output logic sof,
    output logic stuff_drop,
    output logic stuff_err,
    output logic bus_idle
);

    can_state_e       state_r, state_s;
    logic             last_bit_r, last_bit_s;
    logic             exit_pend_r, exit_pend_s;
    logic             dout_s, dout_valid_s, sof_s, stuff_drop_s;
    logic             crc_win_s, stuff_err_s;
    logic             run_inc_s, run_load_s, idle_inc_s, idle_load_s;
    logic [CNT_W-1:0] run_load_val_s, idle_load_val_s;
    logic [CNT_W-1:0] run_cnt_s, idle_cnt_s;

    can_run_counter #(.MAX(STUFF_LEN), .W(CNT_W)) u_run_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (run_inc_s),
        .load     (run_load_s),
        .load_val (run_load_val_s),
        .count    (run_cnt_s)
    );

    can_run_counter #(.MAX(IDLE_LEN), .W(CNT_W)) u_idle_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (idle_inc_s),
        .load     (idle_load_s),
        .load_val (idle_load_val_s),
        .count    (idle_cnt_s)
    );

    // Next-state and next-output decode; nothing moves unless a sample is present.
    always_comb begin
        state_s         = state_r;
        last_bit_s      = last_bit_r;
        exit_pend_s     = exit_pend_r;
        dout_s          = dout;
        dout_valid_s    = 1'b0;
        sof_s           = 1'b0;
        stuff_drop_s    = 1'b0;
        crc_win_s       = crc_win;
        stuff_err_s     = stuff_err;
        run_inc_s       = 1'b0;
        run_load_s      = 1'b0;
        run_load_val_s  = {CNT_W{1'b0}};
        idle_inc_s      = 1'b0;
        idle_load_s     = 1'b0;
        idle_load_val_s = {CNT_W{1'b0}};

        if (sample_en) begin
            case (state_r)
                ST_SYNC: begin
                    if (rx_bit == CAN_RECESSIVE) begin
                        idle_inc_s = 1'b1;
                        if (idle_cnt_s == CNT_W'(IDLE_LEN - 1)) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_SYNC;
                        end
                    end else begin
                        idle_load_s = 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (rx_bit == CAN_DOMINANT) begin
                        state_s        = ST_STUFFED;
                        dout_s         = CAN_DOMINANT;
                        dout_valid_s   = 1'b1;
                        sof_s          = 1'b1;
                        crc_win_s      = 1'b1;
                        stuff_err_s    = 1'b0;
                        last_bit_s     = CAN_DOMINANT;
                        exit_pend_s    = 1'b0;
                        run_load_s     = 1'b1;
                        run_load_val_s = CNT_W'(1);
                        idle_load_s    = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_STUFFED: begin
                    if (run_cnt_s == CNT_W'(STUFF_LEN)) begin
                        if (rx_bit != last_bit_r) begin
                            // Valid stuff bit: swallow it; a pending exit takes effect next sample.
                            stuff_drop_s   = 1'b1;
                            last_bit_s     = rx_bit;
                            run_load_s     = 1'b1;
                            run_load_val_s = CNT_W'(1);
                            exit_pend_s    = !stuff_en;
                        end else begin
                            stuff_err_s     = 1'b1;
                            crc_win_s       = 1'b0;
                            state_s         = ST_SYNC;
                            run_load_s      = 1'b1;
                            idle_load_s     = 1'b1;
                            idle_load_val_s = CNT_W'(rx_bit);
                        end
                    end else if (!stuff_en || exit_pend_r) begin
                        // End of stuffed region: this sample already belongs to PASS.
                        state_s      = ST_PASS;
                        crc_win_s    = 1'b0;
                        exit_pend_s  = 1'b0;
                        dout_s       = rx_bit;
                        dout_valid_s = 1'b1;
                        if (rx_bit == CAN_RECESSIVE) begin
                            idle_inc_s = 1'b1;
                        end else begin
                            idle_load_s = 1'b1;
                        end
                    end else begin
                        dout_s       = rx_bit;
                        dout_valid_s = 1'b1;
                        last_bit_s   = rx_bit;
                        if (rx_bit == last_bit_r) begin
                            run_inc_s = 1'b1;
                        end else begin
                            run_load_s     = 1'b1;
                            run_load_val_s = CNT_W'(1);
                        end
                    end
                end
                ST_PASS: begin
                    dout_s       = rx_bit;
                    dout_valid_s = 1'b1;
                    if (rx_bit == CAN_RECESSIVE) begin
                        idle_inc_s = 1'b1;
                        if (idle_cnt_s == CNT_W'(IDLE_LEN - 1)) begin
                            state_s = ST_IDLE;
                        end else begin
                            state_s = ST_PASS;
                        end
                    end else begin
                        idle_load_s = 1'b1;
                    end
                end
                default: begin
                    state_s = ST_SYNC;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_SYNC;
            last_bit_r  <= CAN_RECESSIVE;
            exit_pend_r <= 1'b0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            sof         <= 1'b0;
            stuff_drop  <= 1'b0;
            crc_win     <= 1'b0;
            stuff_err   <= 1'b0;
            bus_idle    <= 1'b0;
        end else begin
            state_r     <= state_s;
            last_bit_r  <= last_bit_s;
            exit_pend_r <= exit_pend_s;
            dout        <= dout_s;
            dout_valid  <= dout_valid_s;
            sof         <= sof_s;
            stuff_drop  <= stuff_drop_s;
            crc_win     <= crc_win_s;
            stuff_err   <= stuff_err_s;
            bus_idle    <= (state_s == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_can_bit_destuff.sv
// Scoreboard bench for can_bit_destuff: hand-derived expectations queued per sample, checked one clk later.
module tb_can_bit_destuff;

    logic clk;
    logic rst_n;
    logic sample_en;
    logic rx_bit;
    logic stuff_en;
    logic dout;
    logic dout_valid;
    logic crc_win;
    logic sof;
    logic stuff_drop;
    logic stuff_err;
    logic bus_idle;

    typedef struct packed {
        logic v;
        logic d;
        logic s;
        logic drop;
        logic err;
        logic win;
        logic idle;
    } exp_t;

    exp_t sb_q[$];
    int   n_pass;
    int   n_total;

    can_bit_destuff dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_en  (sample_en),
        .rx_bit     (rx_bit),
        .stuff_en   (stuff_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .crc_win    (crc_win),
        .sof        (sof),
        .stuff_drop (stuff_drop),
        .stuff_err  (stuff_err),
        .bus_idle   (bus_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One sample: drive, queue expectation, compare just after the next edge.
    task automatic send(input logic rx, input logic se, input logic ev, input logic ed,
                        input logic es, input logic edrop, input logic eerr,
                        input logic ewin, input logic eidle);
        exp_t e;
        @(negedge clk);
        rx_bit    = rx;
        stuff_en  = se;
        sample_en = 1'b1;
        sb_q.push_back('{v: ev, d: ed, s: es, drop: edrop, err: eerr, win: ewin, idle: eidle});
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        e = sb_q.pop_front();
        check_eq("dout_valid", 32'(dout_valid), 32'(e.v));
        if (e.v) check_eq("dout", 32'(dout), 32'(e.d));
        check_eq("sof", 32'(sof), 32'(e.s));
        check_eq("stuff_drop", 32'(stuff_drop), 32'(e.drop));
        check_eq("stuff_err", 32'(stuff_err), 32'(e.err));
        check_eq("crc_win", 32'(crc_win), 32'(e.win));
        check_eq("bus_idle", 32'(bus_idle), 32'(e.idle));
    endtask

    task automatic sof_bit();
        send(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic dat(input logic rx);
        send(rx, 1'b1, 1'b1, rx, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic stf(input logic rx, input logic se);
        send(rx, se, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic sync_rec(input int n, input logic err, input logic reach);
        for (int i = 0; i < n; i++)
            send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err, 1'b0, reach && (i == n - 1));
    endtask

    task automatic pass_rec(input int n);
        for (int i = 0; i < n; i++)
            send(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i == n - 1);
    endtask

    // Clocks with sample_en low: strobes must be quiet and levels held.
    task automatic gap(input int n, input logic ewin, input logic eidle);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_eq("gap_valid", 32'(dout_valid), 32'(0));
            check_eq("gap_drop", 32'(stuff_drop), 32'(0));
            check_eq("gap_sof", 32'(sof), 32'(0));
            check_eq("gap_win", 32'(crc_win), 32'(ewin));
            check_eq("gap_idle", 32'(bus_idle), 32'(eidle));
        end
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        sample_en = 1'b0;
        rx_bit    = 1'b1;
        stuff_en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_outs", 32'({dout, dout_valid, crc_win, sof, stuff_drop, stuff_err, bus_idle}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Reset -> SYNC; gapped cycles do not count toward idle.
        sync_rec(5, 1'b0, 1'b0);
        gap(3, 1'b0, 1'b0);
        sync_rec(6, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Frame A: dominant run of 5 then stuff bit 1; exit to PASS, dominant restarts idle count.
        sof_bit();
        repeat (4) dat(1'b0);
        stf(1'b1, 1'b1);
        dat(1'b1);
        dat(1'b0);
        send(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        pass_rec(11);

        // Frame B: recessive stuff, then stuff_en drops at the stuff position.
        sof_bit();
        repeat (5) dat(1'b1);
        stf(1'b0, 1'b1);
        dat(1'b1);
        gap(2, 1'b1, 1'b0);
        repeat (4) dat(1'b1);
        stf(1'b0, 1'b0);
        pass_rec(11);

        // Frame C: dominant stuff violation, resync, SOF clears the sticky error.
        sof_bit();
        repeat (4) dat(1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sync_rec(11, 1'b1, 1'b1);
        sof_bit();

        // Frame D: recessive violation seeds the idle count with 1, so 10 more reach idle.
        repeat (5) dat(1'b1);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        sync_rec(10, 1'b1, 1'b1);

        // Frame E: async reset mid-frame, then full resync before SOF.
        sof_bit();
        dat(1'b1);
        dat(1'b0);
        @(negedge clk);
        rx_bit    = 1'b0;
        stuff_en  = 1'b1;
        sample_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", 32'({dout, dout_valid, crc_win, sof, stuff_drop, stuff_err, bus_idle}), 32'(0));
        sample_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sync_rec(10, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        sync_rec(11, 1'b0, 1'b1);
        sof_bit();
        dat(1'b1);

        check_eq("sb_empty", 32'(sb_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
